// File: rtl/game_link_pkg.sv
// Shared constants, state encodings and the score-to-ASCII helper for the
// whack-a-mole PC link.
package game_link_pkg;

    localparam logic [7:0] CH_START = 8'h53;  // 'S'
    localparam logic [7:0] CH_HIT   = 8'h48;  // 'H'
    localparam logic [7:0] CH_ABORT = 8'h58;  // 'X'
    localparam logic [7:0] CH_OVER  = 8'h52;  // 'R'
    localparam logic [7:0] CH_NONE  = 8'h2D;  // '-'
    localparam logic [7:0] CH_EOL   = 8'h0A;
    localparam logic [7:0] CH_ZERO  = 8'h30;  // '0'

    typedef enum logic [1:0] {
        E_IDLE   = 2'd0,
        E_SCAN   = 2'd1,
        E_REPORT = 2'd2
    } enc_state_t;

    typedef enum logic [1:0] {
        T_IDLE     = 2'd0,
        T_START    = 2'd1,
        T_WAITBUSY = 2'd2,
        T_WAITIDLE = 2'd3
    } tx_state_t;

    // Two ASCII digits {tens, ones} of a value already saturated to 0..99.
    function automatic logic [15:0] score_to_ascii(input logic [6:0] val);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = val;
        tens = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {CH_ZERO + {4'h0, tens}, CH_ZERO + {1'b0, rem}};
    endfunction

endpackage

// File: rtl/link_fifo.sv
// Synchronous FIFO with first-word fall-through read data; a write and a read
// in the same cycle are both accepted, even when full.
module link_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok_s, rd_ok_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Accept/pointer/occupancy next-state.
    always_comb begin
        wr_ok_s  = wr_en_i && (!full_o || rd_en_i);
        rd_ok_s  = rd_en_i && !empty_o;
        wr_ptr_d = wr_ok_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: emptying the pointers discards the contents.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/game_uart_link.sv
// PC link: encodes mole patterns and the final score into ASCII frames queued
// for uart_tx, and decodes 'S'/'H'/'X' from uart_rx into control pulses.
module game_uart_link
    import game_link_pkg::*;
#(
    parameter int N_MOLES    = 5,
    parameter int SCORE_BITS = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_MOLES-1:0]          mole_positions,
    input  logic                        game_active,
    input  logic                        game_finish,
    input  logic [SCORE_BITS-1:0]       score,
    input  logic                        tx_busy,
    output logic                        tx_start,
    output logic [7:0]                  tx_data,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_ready,
    output logic                        pc_start,
    output logic                        pc_hit,
    output logic                        pc_abort,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int IDXW = $clog2(N_MOLES + 2);
    localparam int SW   = (SCORE_BITS > 7) ? SCORE_BITS : 7;

    enc_state_t           enc_state_q, enc_state_d;
    tx_state_t            tx_state_q, tx_state_d;
    logic [N_MOLES-1:0]   snap_q, snap_d, last_q, last_d, snap_shift_s;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [15:0]          digits_q, digits_d;
    logic                 pending_q, pending_d, finish_q, active_q;
    logic [2:0]           wb_cnt_q, wb_cnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d, overflow_q, overflow_d;
    logic                 pc_start_q, pc_hit_q, pc_abort_q;
    logic                 enc_wr_s, pop_s, start_report_s, drop_s;
    logic [7:0]           enc_byte_s, fifo_rd_s;
    logic                 fifo_full_s, fifo_empty_s;
    logic [SW-1:0]        score_ext_s;
    logic [6:0]           score_sat_s;

    assign score_ext_s  = SW'(score);
    assign score_sat_s  = (score_ext_s > SW'(99)) ? 7'd99 : score_ext_s[6:0];
    assign snap_shift_s = snap_q >> idx_q;

    // Encoder: pending report wins over mole changes in IDLE.
    always_comb begin
        enc_state_d    = enc_state_q;
        snap_d         = snap_q;
        last_d         = last_q;
        idx_d          = idx_q;
        digits_d       = digits_q;
        enc_wr_s       = 1'b0;
        enc_byte_s     = 8'h00;
        start_report_s = 1'b0;
        case (enc_state_q)
            E_IDLE: begin
                if (pending_q) begin
                    start_report_s = 1'b1;
                    digits_d       = score_to_ascii(score_sat_s);
                    idx_d          = '0;
                    enc_state_d    = E_REPORT;
                end else if (game_active && (mole_positions != last_q)) begin
                    snap_d      = mole_positions;
                    last_d      = mole_positions;
                    idx_d       = '0;
                    enc_state_d = E_SCAN;
                end else begin
                    enc_state_d = E_IDLE;
                end
            end
            E_SCAN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q < IDXW'(N_MOLES)) begin
                    enc_wr_s   = snap_shift_s[0];
                    enc_byte_s = CH_ZERO + 8'(idx_q);
                end else if (idx_q == IDXW'(N_MOLES)) begin
                    enc_wr_s   = (snap_q == '0);
                    enc_byte_s = CH_NONE;
                end else begin
                    enc_wr_s    = 1'b1;
                    enc_byte_s  = CH_EOL;
                    enc_state_d = E_IDLE;
                end
            end
            E_REPORT: begin
                enc_wr_s = 1'b1;
                idx_d    = idx_q + 1'b1;
                case (idx_q)
                    IDXW'(0): enc_byte_s = CH_OVER;
                    IDXW'(1): enc_byte_s = digits_q[15:8];
                    IDXW'(2): enc_byte_s = digits_q[7:0];
                    default: begin
                        enc_byte_s  = CH_EOL;
                        enc_state_d = E_IDLE;
                    end
                endcase
            end
            default: enc_state_d = E_IDLE;
        endcase
        if (active_q && !game_active) begin
            last_d = '0;
        end else begin
            last_d = last_d;
        end
    end

    // Report request and overflow flag bookkeeping.
    always_comb begin
        if (game_finish && !finish_q) begin
            pending_d = 1'b1;
        end else if (start_report_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        drop_s = enc_wr_s && fifo_full_s && !pop_s;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (pc_start_q || (game_active && !active_q)) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // TX sequencer: pop, one-cycle start, wait for busy (bounded), wait for idle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        wb_cnt_d   = wb_cnt_q;
        pop_s      = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!fifo_empty_s && !tx_busy) begin
                    pop_s      = 1'b1;
                    tx_data_d  = fifo_rd_s;
                    tx_state_d = T_START;
                end else begin
                    tx_state_d = T_IDLE;
                end
            end
            T_START: begin
                tx_start_d = 1'b1;
                wb_cnt_d   = 3'd0;
                tx_state_d = T_WAITBUSY;
            end
            T_WAITBUSY: begin
                if (tx_busy || (wb_cnt_q == 3'd3)) begin
                    tx_state_d = T_WAITIDLE;
                end else begin
                    wb_cnt_d = wb_cnt_q + 3'd1;
                end
            end
            T_WAITIDLE: begin
                if (!tx_busy) begin
                    tx_state_d = T_IDLE;
                end else begin
                    tx_state_d = T_WAITIDLE;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            enc_state_q <= E_IDLE;
            tx_state_q  <= T_IDLE;
            snap_q      <= '0;
            last_q      <= '0;
            idx_q       <= '0;
            digits_q    <= 16'h0000;
            pending_q   <= 1'b0;
            finish_q    <= 1'b0;
            active_q    <= 1'b0;
            wb_cnt_q    <= 3'd0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            overflow_q  <= 1'b0;
            pc_start_q  <= 1'b0;
            pc_hit_q    <= 1'b0;
            pc_abort_q  <= 1'b0;
        end else begin
            enc_state_q <= enc_state_d;
            tx_state_q  <= tx_state_d;
            snap_q      <= snap_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            digits_q    <= digits_d;
            pending_q   <= pending_d;
            finish_q    <= game_finish;
            active_q    <= game_active;
            wb_cnt_q    <= wb_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            overflow_q  <= overflow_d;
            pc_start_q  <= rx_ready && (rx_data == CH_START);
            pc_hit_q    <= rx_ready && (rx_data == CH_HIT);
            pc_abort_q  <= rx_ready && (rx_data == CH_ABORT);
        end
    end

    link_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (enc_wr_s),
        .wr_data_i (enc_byte_s),
        .rd_en_i   (pop_s),
        .rd_data_o (fifo_rd_s),
        .level_o   (fifo_level),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign pc_start = pc_start_q;
    assign pc_hit   = pc_hit_q;
    assign pc_abort = pc_abort_q;

endmodule

// File: doc/game_uart_link.md
Name: game_uart_link

Overview:
- Parametrised PC-link engine for the whack-a-mole design. It sits between the game core (mole generator, game FSM, score counter) and the uart_tx/uart_rx byte interfaces.
- Encodes game events into an ASCII byte stream and buffers them in a TX FIFO, so no event is lost while the UART is busy.
- Decodes PC command bytes into single-cycle control pulses.
- Supports N_MOLES moles, multi-hot mole patterns and an end-of-game score report.

Parameters:
- N_MOLES, 5, number of moles (1..10); mole index i is sent as ASCII '0'+i.
- SCORE_BITS, 6, width of the score input.
- FIFO_DEPTH, 8, TX FIFO depth in bytes; must be a power of 2, at least 4.

Ports:
- clock  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-low reset
- mole_positions  in  N_MOLES  current mole pattern, multi-hot allowed
- game_active  in  1  game FSM in RUNNING
- game_finish  in  1  game FSM in FINISH
- score  in  SCORE_BITS  current score, binary
- tx_busy  in  1  uart_tx busy flag
- tx_start  out  1  one-cycle send pulse to uart_tx
- tx_data  out  8  byte to uart_tx
- rx_data  in  8  received byte
- rx_ready  in  1  one-cycle valid pulse for rx_data
- pc_start  out  1  one-cycle pulse on received 'S'
- pc_hit  out  1  one-cycle pulse on received 'H'
- pc_abort  out  1  one-cycle pulse on received 'X'
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of bytes in the TX FIFO
- overflow  out  1  sticky flag: a byte was dropped

Behaviour:
- Reset (reset=0 at a clock edge):
  - All outputs go to 0; tx_data=8'h00.
  - FIFO emptied; snapshot register cleared; pending flags cleared.
  - Reset applies mid-transfer too: the FSMs return to IDLE and the FIFO contents are discarded.
- RX decode:
  - 'S', 'H' and 'X' each produce their pulse on the cycle after rx_ready.
  - Any other byte is ignored.
  - Pulses never overlap, since there is one byte per rx_ready.
- Mole events:
  - While game_active=1, mole_positions != last_snapshot and the encoder FSM is IDLE, the FSM latches snapshot=mole_positions, updates last_snapshot and enters SCAN.
  - SCAN checks one bit per cycle, index 0 to N_MOLES-1, and enqueues '0'+i for each set bit.
  - If the snapshot is all-zero, SCAN enqueues '-' (8'h2D).
  - SCAN then enqueues '\n' (8'h0A) as a frame terminator and returns to IDLE.
  - Changes during SCAN are not lost: the comparison is repeated in IDLE.
- Game-over report:
  - A rising edge of game_finish sets report_pending. This holds even during SCAN.
  - In IDLE, report_pending takes priority over mole changes.
  - REPORT enqueues 'R', tens digit, ones digit, '\n'.
  - The score is saturated to 99 before BCD conversion (repeated subtraction or a shift-add over SCORE_BITS cycles is acceptable).
  - The score is sampled on entry to REPORT.
  - report_pending clears when REPORT starts.
- last_snapshot clears to 0 when game_active falls, so the first mole of the next game is always reported.
- FIFO:
  - Writes occur only from the encoder; reads occur only from the TX sequencer.
  - A write and a read in the same cycle are both accepted, including when full.
  - A write while full, with no read, drops the byte and sets overflow.
  - overflow clears on pc_start or on a rising edge of game_active.
- TX sequencer: states T_IDLE, T_START, T_WAITBUSY, T_WAITIDLE.
  - T_IDLE: when the FIFO is not empty and tx_busy=0, pop the FIFO into tx_data and go to T_START.
  - T_START: drive tx_start=1 for exactly one cycle.
  - T_WAITBUSY: wait until tx_busy=1; time out after 4 cycles and continue anyway.
  - T_WAITIDLE: wait until tx_busy=0, then return to T_IDLE.
  - tx_data is held stable from the pop until the return to T_IDLE.
  - Minimum spacing between bytes is one full UART frame.
- Latency:
  - From the cycle the change is seen in IDLE to the first byte being written into the FIFO: at most N_MOLES+1 cycles.
  - From a byte entering an empty FIFO with the UART idle to tx_start: 2 cycles.

Decomposition:
- Package game_link_pkg holds:
  - ASCII constants: CH_START='S', CH_HIT='H', CH_ABORT='X', CH_OVER='R', CH_NONE='-', CH_EOL=8'h0A.
  - Encoder and TX state encodings.
- One sub-module, link_fifo: a synchronous FIFO parametrised by width and depth, with level, full and empty outputs.

Test Plan:
- Reset held 3 cycles mid-byte, then released -> tx_start=0, fifo_level=0, overflow=0; no stray byte is sent.
- game_active=1, mole_positions 5'b00000 -> 5'b00100 -> tx bytes '2', 8'h0A, in order, each with exactly one tx_start pulse.
- mole_positions=5'b10001 -> bytes '0', '4', 8'h0A; a change to 5'b00000 -> '-', 8'h0A.
- Score 6'd57, rising edge of game_finish in the same cycle as a mole change -> the mole frame completes, then 'R', '5', '7', 8'h0A; score 6'd63 with SCORE_BITS=7 set to 120 -> 'R', '9', '9', 8'h0A.
- FIFO_DEPTH=4, tx_busy forced to 1, three mole changes -> fifo_level saturates at 4, overflow=1; pc_start clears overflow.
- rx_ready with 'S', 'H', 'X', 'Q' -> one-cycle pc_start, pc_hit and pc_abort in turn; 'Q' produces no pulse.
